// File: rtl/circle_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | circle_tracker: decodes the walking-circle 7-segment bus, recovers  |
// | column/row/direction and flags illegal steps.                       |
// | Optional: CIRCLE_TRACKER_STEP_CNT_EN adds the step_cnt_o counter.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module circle_tracker #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = $clog2(NUM_OF_DISPLAYS),
  parameter int LED_LOGIC       = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_OF_DISPLAYS-1:0][7:0] seg7_i,
  input  logic                            clear_i,
  output logic                            valid_o,
  output logic [COL_WIDTH-1:0]            col_o,
  output logic                            row_o,
  output logic                            dir_o,
  output logic                            step_o,
  output logic                            err_o
`ifdef CIRCLE_TRACKER_STEP_CNT_EN
  ,
  output logic [15:0]                     step_cnt_o
`endif
);

  localparam logic [6:0]         c_seg_up   = 7'h63;
  localparam logic [6:0]         c_seg_down = 7'h5C;
  localparam logic [COL_WIDTH:0] c_one      = (COL_WIDTH+1)'(1);
  localparam logic [COL_WIDTH-1:0] c_last_col = COL_WIDTH'(NUM_OF_DISPLAYS-1);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  state_t                          r_state, w_state_nxt;
  logic [NUM_OF_DISPLAYS-1:0][7:0] r_seg_q;
  logic [COL_WIDTH-1:0]            r_col, w_col_nxt;
  logic                            r_row, w_row_nxt;
  logic                            r_dir, w_dir_nxt;
  logic                            r_step, w_step_nxt;

  logic [NUM_OF_DISPLAYS-1:0] w_is_up, w_is_down, w_is_bad, w_dp;
  logic                       w_unused_dp;

  // Per-display classification; decimal points carry no circle information.
  for (genvar d = 0; d < NUM_OF_DISPLAYS; d++) begin : g_classify
    logic [6:0] w_pat;
    assign w_pat        = (LED_LOGIC != 0) ? r_seg_q[d][6:0] : ~r_seg_q[d][6:0];
    assign w_is_up[d]   = (w_pat == c_seg_up);
    assign w_is_down[d] = (w_pat == c_seg_down);
    assign w_is_bad[d]  = !(w_is_up[d] || w_is_down[d] || (w_pat == 7'h00));
    assign w_dp[d]      = r_seg_q[d][7];
  end
  assign w_unused_dp = ^w_dp;

  logic                 w_found, w_multi, w_good;
  logic [COL_WIDTH-1:0] w_frame_col;
  logic                 w_frame_row;

  always_comb begin
    w_found     = 1'b0;
    w_multi     = 1'b0;
    w_frame_col = '0;
    w_frame_row = 1'b0;
    for (int d = 0; d < NUM_OF_DISPLAYS; d++) begin
      if (w_is_up[d] || w_is_down[d]) begin
        if (w_found) w_multi = 1'b1;
        w_found     = 1'b1;
        w_frame_col = COL_WIDTH'(d);
        w_frame_row = w_is_up[d];
      end
    end
    w_good = w_found && !w_multi && !(|w_is_bad);
  end

  // One extra bit keeps col+1 from aliasing to column 0 (no wrap-around).
  logic [COL_WIDTH:0] w_col_ext, w_fcol_ext;
  logic               w_same_row, w_inc, w_dec, w_at_end;
  assign w_col_ext  = {1'b0, r_col};
  assign w_fcol_ext = {1'b0, w_frame_col};
  assign w_same_row = (w_frame_row == r_row);
  assign w_inc      = (w_fcol_ext == w_col_ext + c_one);
  assign w_dec      = (w_fcol_ext + c_one == w_col_ext);
  assign w_at_end   = (r_col == '0) || (r_col == c_last_col);

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_dir_nxt   = r_dir;
    w_step_nxt  = 1'b0;
    case (r_state)
      ST_ACQUIRE: begin
        if (w_good) begin
          w_state_nxt = ST_TRACK;
          w_col_nxt   = w_frame_col;
          w_row_nxt   = w_frame_row;
        end
      end
      ST_TRACK: begin
        if (!w_good) begin
          w_state_nxt = ST_ERROR;
        end else if (!((w_frame_col == r_col) && w_same_row)) begin
          if (w_same_row && w_inc) begin
            w_col_nxt  = w_frame_col;
            w_dir_nxt  = 1'b1;
            w_step_nxt = 1'b1;
          end else if (w_same_row && w_dec) begin
            w_col_nxt  = w_frame_col;
            w_dir_nxt  = 1'b0;
            w_step_nxt = 1'b1;
          end else if ((w_frame_col == r_col) && w_at_end) begin
            w_row_nxt  = w_frame_row;
            w_dir_nxt  = ~r_dir;
            w_step_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        if (clear_i) w_state_nxt = ST_ACQUIRE;
      end
      default: w_state_nxt = ST_ACQUIRE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_ACQUIRE;
      r_seg_q <= '0;
      r_col   <= '0;
      r_row   <= 1'b0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_seg_q <= seg7_i;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
    end
  end

`ifdef CIRCLE_TRACKER_STEP_CNT_EN
  logic [15:0] r_step_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_step_cnt <= 16'd0;
    end else if ((r_state == ST_ERROR) && clear_i) begin
      r_step_cnt <= 16'd0;
    end else if (w_step_nxt) begin
      r_step_cnt <= r_step_cnt + 16'd1;
    end
  end
  assign step_cnt_o = r_step_cnt;
`endif

  assign valid_o = (r_state == ST_TRACK);
  assign err_o   = (r_state == ST_ERROR);
  assign col_o   = r_col;
  assign row_o   = r_row;
  assign dir_o   = r_dir;
  assign step_o  = r_step;

endmodule
`default_nettype wire
